// File: rtl/alu_share_arbiter_pkg.sv
// rtl/alu_share_arbiter_pkg.sv - shared ALU widths, opcodes and opcode helpers
package alu_pkg;

   localparam int ALU_OPW = 6;
   localparam int XLEN    = 32;

   localparam logic [ALU_OPW-1:0] ALU_ADD  = 6'd1;
   localparam logic [ALU_OPW-1:0] ALU_SUB  = 6'd2;
   localparam logic [ALU_OPW-1:0] ALU_XOR  = 6'd3;
   localparam logic [ALU_OPW-1:0] ALU_OR   = 6'd4;
   localparam logic [ALU_OPW-1:0] ALU_AND  = 6'd5;
   localparam logic [ALU_OPW-1:0] ALU_SLL  = 6'd6;
   localparam logic [ALU_OPW-1:0] ALU_SRA  = 6'd7;
   localparam logic [ALU_OPW-1:0] ALU_SRL  = 6'd8;
   localparam logic [ALU_OPW-1:0] ALU_SLT  = 6'd9;
   localparam logic [ALU_OPW-1:0] ALU_SLTU = 6'd10;

   typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_t;

   function automatic logic is_legal_op(input logic [ALU_OPW-1:0] op);
      return (op >= ALU_ADD) && (op <= ALU_SLTU);
   endfunction

   function automatic logic is_shift_op(input logic [ALU_OPW-1:0] op);
      return (op == ALU_SLL) || (op == ALU_SRA) || (op == ALU_SRL);
   endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - requester channels and response buffer port bundle
interface alu_share_arbiter_if #(
   parameter int NREQ = 2,
   parameter int IDW  = 1
);
   logic [NREQ-1:0]                 req_valid;
   logic [NREQ-1:0]                 req_ready;
   logic [NREQ*alu_pkg::ALU_OPW-1:0] req_op;
   logic [NREQ*alu_pkg::XLEN-1:0]    req_a;
   logic [NREQ*alu_pkg::XLEN-1:0]    req_b;
   logic                            rsp_valid;
   logic                            rsp_ready;
   logic [alu_pkg::XLEN-1:0]        rsp_data;
   logic [IDW-1:0]                  rsp_id;
   logic                            rsp_illegal;

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_illegal
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id, rsp_illegal
   );
endinterface

// File: rtl/alu_share_arbiter_alu.sv
// rtl/alu_share_arbiter_alu.sv - shared combinational ALU; undefined ops yield zero
module shared_alu
   import alu_pkg::*;
(
   input  logic [ALU_OPW-1:0] op,
   input  logic [XLEN-1:0]    a,
   input  logic [XLEN-1:0]    b,
   output logic [XLEN-1:0]    y
);
   always_comb begin
      y = '0;
      case (op)
         ALU_ADD:  y = a + b;
         ALU_SUB:  y = a - b;
         ALU_XOR:  y = a ^ b;
         ALU_OR:   y = a | b;
         ALU_AND:  y = a & b;
         ALU_SLL:  y = a << b[4:0];
         ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
         ALU_SRL:  y = a >> b[4:0];
         ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
         default:  y = '0;
      endcase
   end
endmodule

// File: rtl/alu_share_arbiter_rr.sv
// rtl/alu_share_arbiter_rr.sv - combinational round-robin picker, search starts after ptr
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);
   always_comb begin
      int cand;
      cand = 0;
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      for (int off = 1; off <= N; off++) begin
         cand = (int'(ptr) + off) % N;
         if (!any && req[cand]) begin
            any       = 1'b1;
            gnt[cand] = 1'b1;
            idx       = IW'(cand);
         end
      end
   end
endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU with a single-entry response buffer
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IDW  = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_share_arbiter_if.slave bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   buf_state_t           state, state_nxt;
   logic [PW-1:0]        ptr, gidx;
   logic [NREQ-1:0]      gnt;
   logic                 gany, can_accept, xfer, legal;
   logic [ALU_OPW-1:0]   sel_op, alu_op;
   logic [XLEN-1:0]      sel_a, sel_b, alu_b, alu_y;

   rr_arbiter #(.N(NREQ), .IW(PW)) u_rr (
      .req (bus.req_valid),
      .ptr (ptr),
      .gnt (gnt),
      .idx (gidx),
      .any (gany)
   );

   assign sel_op = bus.req_op[int'(gidx)*ALU_OPW +: ALU_OPW];
   assign sel_a  = bus.req_a[int'(gidx)*XLEN +: XLEN];
   assign sel_b  = bus.req_b[int'(gidx)*XLEN +: XLEN];
   assign legal  = is_legal_op(sel_op);
   // Illegal ops never reach the ALU; shift amounts are clamped to 5 bits.
   assign alu_op = legal ? sel_op : '0;
   assign alu_b  = is_shift_op(sel_op) ? {{(XLEN-5){1'b0}}, sel_b[4:0]} : sel_b;
   assign xfer   = gany & can_accept & rst_n;

   shared_alu u_alu (
      .op (alu_op),
      .a  (sel_a),
      .b  (alu_b),
      .y  (alu_y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= BUF_EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         BUF_EMPTY: if (xfer) state_nxt = BUF_FULL;
         BUF_FULL:  if (!xfer && bus.rsp_ready) state_nxt = BUF_EMPTY;
         default:   state_nxt = BUF_EMPTY;
      endcase
   end

   always_comb begin
      bus.rsp_valid = (state == BUF_FULL);
      can_accept    = (state == BUF_EMPTY) || bus.rsp_ready;
      bus.req_ready = gnt & {NREQ{can_accept & rst_n}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rsp_data    <= '0;
         bus.rsp_id      <= '0;
         bus.rsp_illegal <= 1'b0;
         ptr             <= PW'(NREQ-1);
      end else if (xfer) begin
         bus.rsp_data    <= legal ? alu_y : '0;
         bus.rsp_id      <= IDW'(gidx);
         bus.rsp_illegal <= !legal;
         ptr             <= gidx;
      end
   end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed vector bench for alu_share_arbiter
module tb_alu_share_arbiter;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_share_arbiter_if #(.NREQ(2), .IDW(1)) bus();

   alu_share_arbiter #(.NREQ(2), .IDW(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   typedef struct {
      int          r;
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] y;
      logic        ill;
   } vec_t;

   vec_t tv[14];

   task automatic set_req(input int r, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.req_valid[r]      = 1'b1;
      bus.req_op[r*6 +: 6]  = op;
      bus.req_a[r*32 +: 32] = a;
      bus.req_b[r*32 +: 32] = b;
   endtask

   task automatic clear_req();
      bus.req_valid = '0;
      bus.req_op    = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
   endtask

   initial begin
      logic [1:0] e;
      tv[0]  = '{0, ALU_ADD,  32'd5,        32'd7,        32'd12,       1'b0};
      tv[1]  = '{0, ALU_SUB,  32'd3,        32'd5,        32'hFFFFFFFE, 1'b0};
      tv[2]  = '{1, ALU_XOR,  32'hF0,       32'h0F,       32'hFF,       1'b0};
      tv[3]  = '{0, ALU_OR,   32'hF0F0,     32'h0F00,     32'hFFF0,     1'b0};
      tv[4]  = '{1, ALU_AND,  32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0};
      tv[5]  = '{0, ALU_SLL,  32'd1,        32'h24,       32'h10,       1'b0};
      tv[6]  = '{1, ALU_SRA,  32'h80000000, 32'h21,       32'hC0000000, 1'b0};
      tv[7]  = '{1, ALU_SRL,  32'h80000000, 32'h21,       32'h40000000, 1'b0};
      tv[8]  = '{0, ALU_SLT,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
      tv[9]  = '{0, ALU_SLTU, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};
      tv[10] = '{0, 6'd0,     32'd5,        32'd7,        32'd0,        1'b1};
      tv[11] = '{1, 6'd11,    32'd5,        32'd7,        32'd0,        1'b1};
      tv[12] = '{0, 6'd63,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b1};
      tv[13] = '{0, ALU_ADD,  32'hFFFFFFFF, 32'd2,        32'd1,        1'b0};

      clear_req();
      bus.rsp_ready = 1'b1;
      bus.req_valid = 2'b11;
      #12;
      chk("reset_req_ready",   32'(bus.req_ready),   32'd0);
      chk("reset_rsp_valid",   32'(bus.rsp_valid),   32'd0);
      chk("reset_rsp_data",    bus.rsp_data,         32'd0);
      chk("reset_rsp_id",      32'(bus.rsp_id),      32'd0);
      chk("reset_rsp_illegal", 32'(bus.rsp_illegal), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         clear_req();
         set_req(tv[i].r, tv[i].op, tv[i].a, tv[i].b);
         e = '0;
         e[tv[i].r] = 1'b1;
         #1;
         chk($sformatf("vec%0d_ready", i), 32'(bus.req_ready), 32'(e));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_valid", i), 32'(bus.rsp_valid), 32'd1);
         chk($sformatf("vec%0d_data", i), bus.rsp_data, tv[i].y);
         chk($sformatf("vec%0d_id", i), 32'(bus.rsp_id), 32'(tv[i].r));
         chk($sformatf("vec%0d_illegal", i), 32'(bus.rsp_illegal), 32'(tv[i].ill));
         @(negedge clk);
      end

      clear_req();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      @(negedge clk);

      set_req(0, ALU_SUB, 32'd3, 32'd5);
      set_req(1, ALU_XOR, 32'hF0, 32'h0F);
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("alt%0d_ready", k), 32'(bus.req_ready), (k % 2 == 1) ? 32'd2 : 32'd1);
         @(posedge clk);
         #1;
         chk($sformatf("alt%0d_valid", k), 32'(bus.rsp_valid), 32'd1);
         chk($sformatf("alt%0d_data", k), bus.rsp_data, (k % 2 == 1) ? 32'hFF : 32'hFFFFFFFE);
         chk($sformatf("alt%0d_id", k), 32'(bus.rsp_id), 32'(k % 2));
         @(negedge clk);
      end

      bus.rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("stall%0d_ready", k), 32'(bus.req_ready), 32'd0);
         chk($sformatf("stall%0d_valid", k), 32'(bus.rsp_valid), 32'd1);
         chk($sformatf("stall%0d_data", k), bus.rsp_data, 32'hFF);
         chk($sformatf("stall%0d_id", k), 32'(bus.rsp_id), 32'd1);
         chk($sformatf("stall%0d_illegal", k), 32'(bus.rsp_illegal), 32'd0);
         @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      #1;
      chk("release_ready", 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      #1;
      chk("release_valid", 32'(bus.rsp_valid), 32'd1);
      chk("release_data", bus.rsp_data, 32'hFFFFFFFE);
      chk("release_id", 32'(bus.rsp_id), 32'd0);
      @(negedge clk);
      clear_req();
      @(posedge clk);
      #1;
      chk("drain_valid", 32'(bus.rsp_valid), 32'd0);
      chk("drain_data_kept", bus.rsp_data, 32'hFFFFFFFE);

      @(negedge clk);
      set_req(1, ALU_XOR, 32'hF0, 32'h0F);
      bus.rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("prerst_valid", 32'(bus.rsp_valid), 32'd1);
      chk("prerst_id", 32'(bus.rsp_id), 32'd1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(bus.rsp_valid), 32'd0);
      chk("async_rst_data", bus.rsp_data, 32'd0);
      chk("async_rst_ready", 32'(bus.req_ready), 32'd0);
      set_req(0, ALU_ADD, 32'd5, 32'd7);
      @(negedge clk);
      rst_n = 1'b1;
      bus.rsp_ready = 1'b1;
      #1;
      chk("postrst_ready", 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      #1;
      chk("postrst_valid", 32'(bus.rsp_valid), 32'd1);
      chk("postrst_data", bus.rsp_data, 32'd12);
      chk("postrst_id", 32'(bus.rsp_id), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
